// File: rtl/mux_arbiter8_pkg.sv
// Shared definitions for the 8-way round-robin mux arbiter.
// Holds the state encoding, the requester count and the pointer reset value.
package mux_arbiter8_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int NREQ = 8;

  // The pointer starts at the last requester, so requester 0 wins first.
  localparam logic [2:0] PTR_RST = 3'd7;

endpackage

// File: rtl/mux8x1.sv
// 8-to-1 word multiplexer selected by a 3-bit index.
module mux8x1 #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] d3,
  input  logic [WIDTH-1:0] d4,
  input  logic [WIDTH-1:0] d5,
  input  logic [WIDTH-1:0] d6,
  input  logic [WIDTH-1:0] d7,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = d0;
    case (s)
      3'd0:    y = d0;
      3'd1:    y = d1;
      3'd2:    y = d2;
      3'd3:    y = d3;
      3'd4:    y = d4;
      3'd5:    y = d5;
      3'd6:    y = d6;
      default: y = d7;
    endcase
  end

endmodule

// File: rtl/rr_pick8.sv
// Round-robin search over 8 requests.
// The search starts just after ptr and wraps from 7 back to 0.
module rr_pick8
  import mux_arbiter8_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [2:0]      ptr,
  output logic            any,
  output logic [2:0]      idx
);

  logic [2:0] cand;

  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    // Offset 8 wraps to ptr itself, so the last winner is checked last.
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + 3'(k);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter8.sv
// Eight requesters share one registered output word, served in round-robin order.
// state | meaning
// EMPTY | F holds no pending word; F_ready is ignored
// FULL  | F holds a word waiting for downstream to accept it
module mux_arbiter8
  import mux_arbiter8_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] D0,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic [WIDTH-1:0] D3,
  input  logic [WIDTH-1:0] D4,
  input  logic [WIDTH-1:0] D5,
  input  logic [WIDTH-1:0] D6,
  input  logic [WIDTH-1:0] D7,
  output logic [NREQ-1:0]  gnt,
  output logic [2:0]       S,
  output logic [WIDTH-1:0] F,
  output logic             F_valid,
  input  logic             F_ready
);

  state_t           state, state_nxt;
  logic [2:0]       ptr;
  logic [2:0]       pick_idx;
  logic             pick_any;
  logic [WIDTH-1:0] mux_y;
  logic             loadable;
  logic             load;

  rr_pick8 u_pick (
    .req (req),
    .ptr (ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  mux8x1 #(.WIDTH(WIDTH)) u_mux (
    .s  (pick_idx),
    .d0 (D0),
    .d1 (D1),
    .d2 (D2),
    .d3 (D3),
    .d4 (D4),
    .d5 (D5),
    .d6 (D6),
    .d7 (D7),
    .y  (mux_y)
  );

  assign F_valid = (state == FULL);

  always_comb begin
    loadable  = (state == EMPTY) || F_ready;
    load      = loadable && pick_any && !rst;
    gnt       = '0;
    state_nxt = state;
    if (load) gnt[pick_idx] = 1'b1;
    case (state)
      EMPTY:   if (load) state_nxt = FULL;
      FULL:    if (F_ready && !pick_any) state_nxt = EMPTY;
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
      F     <= '0;
      S     <= '0;
      ptr   <= PTR_RST;
    end else begin
      state <= state_nxt;
      if (load) begin
        F   <= mux_y;
        S   <= pick_idx;
        ptr <= pick_idx;
      end
    end
  end

endmodule

// File: tb/tb_mux_arbiter8.sv
// Bench for mux_arbiter8: directed scenarios plus randomized traffic,
// checked every cycle against a round-robin model of the output register.
module tb_mux_arbiter8;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    req;
  logic [W-1:0]  d [8];
  logic [7:0]    gnt;
  logic [2:0]    S;
  logic [W-1:0]  F;
  logic          F_valid;
  logic          F_ready;

  int n_tests = 0;
  int n_fail  = 0;

  bit           m_fv;
  logic [W-1:0] m_F;
  int           m_S;
  int           m_ptr;
  int           last_win;
  int           wcnt [8];
  logic [7:0]   pend;

  always #5 clk = ~clk;

  mux_arbiter8 #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .D0      (d[0]),
    .D1      (d[1]),
    .D2      (d[2]),
    .D3      (d[3]),
    .D4      (d[4]),
    .D5      (d[5]),
    .D6      (d[6]),
    .D7      (d[7]),
    .gnt     (gnt),
    .S       (S),
    .F       (F),
    .F_valid (F_valid),
    .F_ready (F_ready)
  );

  function automatic int winner(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, compare mid-cycle, advance the model at the edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic rdy, input int exp_gnt);
    logic [7:0] eg;
    int w;
    @(negedge clk);
    rst = r; req = rq; F_ready = rdy;
    #1;
    w = winner(rq, m_ptr);
    eg = '0;
    last_win = -1;
    if (!r && (!m_fv || rdy) && w >= 0) begin
      eg = 8'd1 << w;
      last_win = w;
    end
    chk("gnt", gnt, eg);
    chk("F_valid", F_valid, m_fv);
    chk("F", F, m_F);
    chk("S", S, m_S);
    if (exp_gnt >= 0) begin
      chk("model_gnt_lit", eg, exp_gnt);
      chk("gnt_lit", gnt, exp_gnt);
    end
    @(posedge clk);
    if (r) begin
      m_fv = 0; m_F = '0; m_S = 0; m_ptr = 7;
    end else if (last_win >= 0) begin
      m_fv = 1; m_F = d[last_win]; m_S = last_win; m_ptr = last_win;
    end else if (m_fv && rdy) begin
      m_fv = 0;
    end
    #1;
  endtask

  initial begin
    logic r, rdy;
    logic [7:0] alt [4];
    alt[0] = 8'h04; alt[1] = 8'h40; alt[2] = 8'h04; alt[3] = 8'h40;
    for (int i = 0; i < 8; i++) begin
      d[i] = $urandom;
      wcnt[i] = 0;
    end
    rst = 1'b1; req = '0; F_ready = 1'b0;
    m_fv = 0; m_F = '0; m_S = 0; m_ptr = 7; last_win = -1;
    pend = '0;

    // reset with all requesting, then rotation 01..80,01
    step(1'b1, 8'hFF, 1'b1, 0);
    chk("rst_F", F, 0);
    chk("rst_F_valid", F_valid, 0);
    for (int i = 0; i < 9; i++) step(1'b0, 8'hFF, 1'b1, 1 << (i % 8));

    // single requester
    d[5] = 32'hDEADBEEF;
    step(1'b0, 8'h20, 1'b1, 8'h20);
    chk("single_F", F, 32'hDEADBEEF);
    chk("single_S", S, 5);
    chk("single_F_valid", F_valid, 1);

    // stall, then release loads in the same cycle (ptr=5 -> search 6,7,0)
    repeat (4) step(1'b0, 8'h03, 1'b0, 0);
    chk("stall_F", F, 32'hDEADBEEF);
    chk("stall_S", S, 5);
    step(1'b0, 8'h03, 1'b1, 8'h01);

    // fairness between 2 and 6
    for (int i = 0; i < 4; i++) step(1'b0, 8'h44, 1'b1, alt[i]);

    // wrap from ptr=6
    step(1'b0, 8'h41, 1'b1, 8'h01);
    step(1'b0, 8'h41, 1'b1, 8'h40);

    // reset while FULL
    step(1'b0, 8'h10, 1'b1, 8'h10);
    step(1'b1, 8'h10, 1'b1, 0);
    chk("midrst_F_valid", F_valid, 0);
    chk("midrst_F", F, 0);
    step(1'b0, 8'hFF, 1'b1, 8'h01);

    // randomized traffic with requesters holding until granted
    step(1'b1, 8'h00, 1'b0, 0);
    for (int c = 0; c < 3000; c++) begin
      r   = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      step(r, pend, rdy, -1);
      if (r) begin
        for (int i = 0; i < 8; i++) wcnt[i] = 0;
      end else if (last_win >= 0) begin
        chk("fair_wait", wcnt[last_win] <= 7, 1);
        for (int i = 0; i < 8; i++)
          if (i != last_win && pend[i]) wcnt[i]++;
        wcnt[last_win] = 0;
        d[last_win] = $urandom;
        if ($urandom_range(0, 1) == 1) pend[last_win] = 1'b0;
      end
      for (int i = 0; i < 8; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          wcnt[i] = 0;
          d[i] = $urandom;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_arbiter8.md
MUX_ARBITER8 -- requirements
Module: mux_arbiter8

Interface
REQ-001 Parameter WIDTH, default 32, data word width of each requester and of the output.
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  8  per-requester request; bit i means word Di is pending.
REQ-005 D0..D7  input  WIDTH each  requester data words.
REQ-006 gnt  output  8  one-hot grant; bit i high means Di is captured this cycle.
REQ-007 S  output  3  index of the requester currently held in the output register.
REQ-008 F  output  WIDTH  registered selected word.
REQ-009 F_valid  output  1  F holds a word not yet accepted downstream.
REQ-010 F_ready  input  1  downstream accepts F when F_valid & F_ready.

Function
REQ-011 The output register SHALL be loadable when F_valid=0 or (F_valid & F_ready).
- Load when loadable and req != 0.
REQ-012 Winner SHALL be the first set req bit searched from (ptr+1) mod 8 upward, wrapping 7->0.
- ptr is the index of the last granted requester.
REQ-013 On a load cycle the block SHALL:
- assert gnt[winner] combinationally in that same cycle;
- register F<=D[winner], S<=winner, ptr<=winner and F_valid<=1 at the edge.
REQ-014 gnt SHALL be all-zero in every non-load cycle and SHALL never have more than one bit set.
REQ-015 Latency SHALL be one cycle: req seen with the register loadable at edge n gives F_valid=1 and the data at edge n+1.
REQ-016 Throughput SHALL be one word per cycle: accept and new load in the same cycle give F_valid continuously high.
REQ-017 Accept with req=0 SHALL clear F_valid at the next edge; F and S retain their last values.
REQ-018 While F_valid=1 and F_ready=0, F, S, ptr and F_valid SHALL hold and gnt SHALL stay zero (stall).
REQ-019 Requesters hold req[i] and Di stable until gnt[i]; they may drop or re-raise req[i] the cycle after the grant.
REQ-020 A requester re-raising immediately SHALL NOT be granted again before every other requester that was pending has been served once (fairness: wait ≤ 7 grants).
REQ-021 State machine, two states:
- EMPTY (F_valid=0) -> FULL on load.
- FULL: stays FULL on stall or on accept plus load; goes to EMPTY on accept with req=0.
REQ-022 F_ready while EMPTY SHALL be ignored.

Reset
REQ-023 With rst=1 at an edge, the block SHALL set F=0, S=0, F_valid=0, ptr=7 (requester 0 highest priority first), state=EMPTY.
REQ-024 rst SHALL override any simultaneous load or accept.
REQ-025 gnt SHALL be forced to zero while rst=1.
REQ-026 A word held in F when reset occurs is discarded and not re-presented.

Structure
REQ-027 A shared package SHALL hold:
- the state encoding (EMPTY=0, FULL=1);
- the constant NREQ=8;
- the pointer reset value 7.
REQ-028 The round-robin search SHALL be a sub-module rr_pick8 (inputs req[7:0], ptr[2:0]; outputs any, idx[2:0]).
REQ-029 The data path SHALL use the existing mux8x1 with S driven from idx, feeding the output register.

Verification
REQ-030 Reset: req=8'hFF during rst -> gnt=0, F_valid=0, F=0. After release with F_ready=1 -> gnt=8'h01 first, then 02,04,...,80,01 on consecutive cycles.
REQ-031 Single requester: req=8'h20, D5=32'hDEADBEEF, F_ready=1 -> gnt=8'h20 at cycle n; F=32'hDEADBEEF, S=5, F_valid=1 at n+1.
REQ-032 Stall: F_valid=1, F_ready=0 for 4 cycles with req=8'h03 -> F, S stable; gnt=0 all 4 cycles. Then F_ready=1 -> a load occurs in that same cycle.
REQ-033 Fairness: req[2] re-raised every cycle, req[6] held -> grants alternate 2,6,2,6.
REQ-034 Wrap: ptr=6, req=8'h41 -> grant 0 before 6 again (search 7,0,...).
REQ-035 Mid-operation reset: rst=1 while FULL with F_ready=1 and req=8'h10 -> no grant; next cycle F_valid=0, ptr=7.
